// File: rtl/miner_pkg.sv
// Shared miner constants: word/block geometry, memory-mapped addresses and loader states.
package miner_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 24;

    localparam logic [27:0] ATOM_REG_ADDR    = 28'h8000000;
    localparam logic [27:0] HDWR_REG_ADDR    = 28'h8000004;
    localparam logic [27:0] MINE_BLOCK_ADDR  = 28'h8000008;
    localparam logic [27:0] NONCE_BLOCK_ADDR = 28'h8000068;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } loader_state_t;

endpackage

// File: rtl/word_shift_reg.sv
// Left-shifting word register: new words enter at the LSBs, so the oldest word ends up in the MSBs.
module word_shift_reg #(
    parameter int WIDTH   = 768,
    parameter int SHIFT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [SHIFT_W-1:0] i_din,
    output logic [WIDTH-1:0]   o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear together with enable loads the word into an otherwise empty register.
    always_ff @(posedge clk) begin
        if (!reset)
            r_q <= '0;
        else if (i_clr)
            r_q <= i_en ? WIDTH'(i_din) : '0;
        else if (i_en)
            r_q <= {r_q[WIDTH-SHIFT_W-1:0], i_din};
    end

    assign o_q = r_q;

endmodule

// File: rtl/block_loader.sv
// Collects the 24-word mining block from the memory manager and hands it to the hashing core.
// Define BLOCK_LOADER_BSWAP_EN to byte-swap each word (little-endian to SHA-256 order) before capture.
module block_loader
    import miner_pkg::*;
#(
    parameter int WORD_W      = miner_pkg::WORD_W,
    parameter int BLOCK_WORDS = miner_pkg::BLOCK_WORDS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          word_valid,
    input  logic [WORD_W-1:0]             word_data,
    output logic                          work_valid,
    input  logic                          work_ready,
    output logic [WORD_W*BLOCK_WORDS-1:0] work_data,
    output logic                          busy,
    output logic                          done,
    output logic                          stray,
    output logic [4:0]                    words_loaded
);

    localparam logic [4:0] LAST_IDX = 5'(BLOCK_WORDS - 1);

    loader_state_t r_state, w_state_nxt;
    logic [4:0]    r_cnt, w_cnt_nxt;
    logic          r_stray, w_stray_nxt;
    logic          r_done, w_done_nxt;
    logic          w_shift_en, w_shift_clr;
    logic [WORD_W-1:0] w_word;

`ifdef BLOCK_LOADER_BSWAP_EN
    assign w_word = {<<8{word_data}};
`else
    assign w_word = word_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stray <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stray <= w_stray_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stray_nxt = r_stray;
        w_done_nxt  = 1'b0;
        w_shift_en  = 1'b0;
        w_shift_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (word_valid)
                    w_stray_nxt = 1'b1;
                // An accepted start wins over a stray word on the same edge.
                if (start) begin
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = '0;
                    w_stray_nxt = 1'b0;
                    w_shift_clr = 1'b1;
                end
            end
            LOAD: begin
                if (start) begin
                    w_shift_clr = 1'b1;
                    w_shift_en  = word_valid;
                    w_cnt_nxt   = word_valid ? 5'd1 : 5'd0;
                end else if (word_valid) begin
                    w_shift_en = 1'b1;
                    w_cnt_nxt  = r_cnt + 5'd1;
                    if (r_cnt == LAST_IDX)
                        w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (word_valid)
                    w_stray_nxt = 1'b1;
                if (work_ready) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    word_shift_reg #(
        .WIDTH  (WORD_W * BLOCK_WORDS),
        .SHIFT_W(WORD_W)
    ) u_shift (
        .clk  (clk),
        .reset(reset),
        .i_clr(w_shift_clr),
        .i_en (w_shift_en),
        .i_din(w_word),
        .o_q  (work_data)
    );

    assign work_valid   = (r_state == HOLD);
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign stray        = r_stray;
    assign words_loaded = r_cnt;

endmodule

// File: tb/tb_block_loader.sv
// Directed bench for block_loader: load, backpressure, stray, restart, reset and optional byte swap.
module tb_block_loader;

    localparam int WW = 32;
    localparam int BW = 24;
    localparam int DW = WW * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          word_valid;
    logic [WW-1:0] word_data;
    logic          work_valid;
    logic          work_ready;
    logic [DW-1:0] work_data;
    logic          busy;
    logic          done;
    logic          stray;
    logic [4:0]    words_loaded;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_data;

    always #5 clk = ~clk;

    block_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .work_valid  (work_valid),
        .work_ready  (work_ready),
        .work_data   (work_data),
        .busy        (busy),
        .done        (done),
        .stray       (stray),
        .words_loaded(words_loaded)
    );

    function automatic logic [WW-1:0] xf(input logic [WW-1:0] w);
`ifdef BLOCK_LOADER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_work_data"}, work_data, '0);
        check({tag, "_work_valid"}, DW'(work_valid), '0);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_done"}, DW'(done), '0);
        check({tag, "_stray"}, DW'(stray), '0);
        check({tag, "_words_loaded"}, DW'(words_loaded), '0);
    endtask

    // One word on one edge; the expected block model shifts the same way.
    task automatic send_word(input logic [WW-1:0] w);
        word_valid = 1'b1;
        word_data  = w;
        tick();
        word_valid = 1'b0;
        exp_data   = {exp_data[DW-WW-1:0], xf(w)};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic handoff(input string tag);
        work_ready = 1'b1;
        tick();
        work_ready = 1'b0;
        check({tag, "_ho_valid"}, DW'(work_valid), '0);
        check({tag, "_ho_busy"}, DW'(busy), '0);
        check({tag, "_ho_done"}, DW'(done), 1);
        tick();
        check({tag, "_ho_done_low"}, DW'(done), '0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        work_ready = 1'b0;
        exp_data   = '0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b1;

        // Basic back-to-back load
        pulse_start();
        check("basic_busy", DW'(busy), 1);
        check("basic_cnt0", DW'(words_loaded), 0);
        for (int i = 1; i <= BW; i++) begin
            if (i == BW) check("basic_not_yet_valid", DW'(work_valid), 0);
            send_word(WW'(i));
        end
        check("basic_valid", DW'(work_valid), 1);
        check("basic_cnt24", DW'(words_loaded), 24);
`ifdef BLOCK_LOADER_BSWAP_EN
        check("basic_msw", DW'(work_data[DW-1 -: WW]), DW'(32'h01000000));
        check("basic_lsw", DW'(work_data[WW-1:0]), DW'(32'h18000000));
`else
        check("basic_msw", DW'(work_data[DW-1 -: WW]), DW'(32'h00000001));
        check("basic_lsw", DW'(work_data[WW-1:0]), DW'(32'h00000018));
`endif
        check("basic_data", work_data, exp_data);
        handoff("basic");

        // Stray word in IDLE
        word_valid = 1'b1;
        word_data  = 32'hDEADBEEF;
        tick();
        word_valid = 1'b0;
        check("idle_stray", DW'(stray), 1);
        check("idle_stray_data", work_data, exp_data);
        check("idle_stray_busy", DW'(busy), 0);

        // Gapped load, then backpressure; start clears stray
        pulse_start();
        check("gap_stray_clr", DW'(stray), 0);
        exp_data = '0;
        send_word(32'h11223344);
        tick();
        for (int i = 2; i <= BW; i++) begin
            send_word(32'h0A000000 + WW'(i));
            if (i < BW) begin
                check("gap_idle_no_valid", DW'(work_valid), 0);
                tick();
            end
        end
        check("gap_valid", DW'(work_valid), 1);
`ifdef BLOCK_LOADER_BSWAP_EN
        check("gap_first_word", DW'(work_data[DW-1 -: WW]), DW'(32'h44332211));
`else
        check("gap_first_word", DW'(work_data[DW-1 -: WW]), DW'(32'h11223344));
`endif
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid", DW'(work_valid), 1);
            check("bp_data", work_data, exp_data);
            check("bp_done", DW'(done), 0);
        end
        // Stray in HOLD, then start in HOLD
        word_valid = 1'b1;
        word_data  = 32'hCAFEF00D;
        tick();
        word_valid = 1'b0;
        check("hold_stray", DW'(stray), 1);
        check("hold_stray_data", work_data, exp_data);
        pulse_start();
        check("hold_start_valid", DW'(work_valid), 1);
        check("hold_start_busy", DW'(busy), 1);
        check("hold_start_cnt", DW'(words_loaded), 24);
        check("hold_start_stray", DW'(stray), 1);
        handoff("gap");

        // Restart after 10 words; restart edge carries word 1
        pulse_start();
        for (int i = 1; i <= 10; i++) send_word(32'hB0000000 + WW'(i));
        check("restart_cnt10", DW'(words_loaded), 10);
        exp_data   = '0;
        start      = 1'b1;
        send_word(32'hC0000001);
        start      = 1'b0;
        check("restart_cnt1", DW'(words_loaded), 1);
        for (int i = 2; i <= BW; i++) begin
            if (i == BW) check("restart_not_valid", DW'(work_valid), 0);
            send_word(32'hC0000000 + WW'(i));
        end
        check("restart_valid", DW'(work_valid), 1);
        check("restart_cnt24", DW'(words_loaded), 24);
        check("restart_data", work_data, exp_data);
        handoff("restart");

        // Reset mid-load after 12 words
        pulse_start();
        for (int i = 1; i <= 12; i++) send_word(32'hE0000000 + WW'(i));
        reset = 1'b0;
        tick();
        check_reset_vals("midreset");
        reset = 1'b1;
        exp_data = '0;
        pulse_start();
        for (int i = 1; i <= BW; i++) send_word(32'hA5000000 + WW'(i * 3));
        check("fresh_valid", DW'(work_valid), 1);
        check("fresh_cnt", DW'(words_loaded), 24);
        check("fresh_data", work_data, exp_data);
        handoff("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
